// File: rtl/cvita_hdr_parser_pkg.sv
// CVITA header field positions, packet-type codes and length helpers,
// shared by the header encoder and parser.
package cvita_pkg;

  localparam int PKT_TYPE_MSB = 63;
  localparam int PKT_TYPE_LSB = 62;
  localparam int HAS_TIME_BIT = 61;
  localparam int EOB_BIT      = 60;
  localparam int SEQNUM_MSB   = 59;
  localparam int SEQNUM_LSB   = 48;
  localparam int LEN_MSB      = 47;
  localparam int LEN_LSB      = 32;
  localparam int SRC_SID_MSB  = 31;
  localparam int SRC_SID_LSB  = 16;
  localparam int DST_SID_MSB  = 15;
  localparam int DST_SID_LSB  = 0;

  typedef enum logic [1:0] {
    DATA = 2'b00,
    FC   = 2'b01,
    CMD  = 2'b10,
    RESP = 2'b11
  } pkt_type_e;

  localparam logic [15:0] HDR_LEN_NOTIME = 16'd8;
  localparam logic [15:0] HDR_LEN_TIME   = 16'd16;

  typedef enum logic [1:0] {S_HDR, S_TIME, S_BODY, S_DROP} state_e;

  // Payload beats minus one; caller guarantees plen > 0.
  function automatic logic [15:0] beats_m1(input logic [15:0] plen);
    logic [16:0] c;
    c = ({1'b0, plen} + 17'd7) >> 3;
    return c[15:0] - 16'd1;
  endfunction

endpackage

// File: rtl/cvita_hdr_parser.sv
// CVITA receive parser: registers header fields, forwards payload beats with
// enforced framing. Optional CVITA_HDR_PARSER_SEQ_CHECK_EN adds o_err_seq.
module cvita_hdr_parser
  import cvita_pkg::*;
#(
  parameter logic [15:0] MAX_LEN_BYTES = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [63:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic [1:0]  o_pkt_type,
  output logic        o_eob,
  output logic        o_has_time,
  output logic [11:0] o_seqnum,
  output logic [15:0] o_payload_length,
  output logic [15:0] o_src_sid,
  output logic [15:0] o_dst_sid,
  output logic [63:0] o_vita_time,
  output logic        o_hdr_stb,
`ifdef CVITA_HDR_PARSER_SEQ_CHECK_EN
  output logic        o_err_seq,
`endif
  output logic        o_err_len
);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [63:0] hdr_q, hdr_d;
  logic        stb_q, err_q, err_d;
  logic        pub;
  logic [63:0] pub_word, pub_time;
  logic [15:0] in_len, in_hlen, in_plen, pub_len;
  logic        in_ht;

  assign in_len  = i_tdata[LEN_MSB:LEN_LSB];
  assign in_ht   = i_tdata[HAS_TIME_BIT];
  assign in_hlen = in_ht ? HDR_LEN_TIME : HDR_LEN_NOTIME;
  assign in_plen = in_len - in_hlen;
  assign pub_len = pub_word[LEN_MSB:LEN_LSB] -
                   (pub_word[HAS_TIME_BIT] ? HDR_LEN_TIME : HDR_LEN_NOTIME);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hdr_d    = hdr_q;
    err_d    = 1'b0;
    pub      = 1'b0;
    pub_word = i_tdata;
    pub_time = '0;
    i_tready = 1'b0;
    o_tvalid = 1'b0;
    o_tdata  = '0;
    o_tlast  = 1'b0;
    case (state_q)
      S_HDR: begin
        i_tready = 1'b1;
        if (i_tvalid) begin
          hdr_d = i_tdata;
          cnt_d = beats_m1(in_plen);
          if (in_len < in_hlen || in_len > MAX_LEN_BYTES || (i_tlast && in_ht)) begin
            err_d   = 1'b1;
            state_d = i_tlast ? S_HDR : S_DROP;
          end else if (in_ht) begin
            state_d = S_TIME;
          end else begin
            pub = 1'b1;
            if (in_len == HDR_LEN_NOTIME) begin
              if (!i_tlast) begin
                err_d   = 1'b1;
                state_d = S_DROP;
              end
            end else begin
              state_d = S_BODY;
            end
          end
        end
      end
      S_TIME: begin
        i_tready = 1'b1;
        if (i_tvalid) begin
          pub      = 1'b1;
          pub_word = hdr_q;
          pub_time = i_tdata;
          if (hdr_q[LEN_MSB:LEN_LSB] == HDR_LEN_TIME) begin
            err_d   = !i_tlast;
            state_d = i_tlast ? S_HDR : S_DROP;
          end else if (i_tlast) begin
            err_d   = 1'b1;
            state_d = S_HDR;
          end else begin
            state_d = S_BODY;
          end
        end
      end
      S_BODY: begin
        i_tready = o_tready;
        o_tvalid = i_tvalid;
        o_tdata  = i_tdata;
        o_tlast  = i_tlast || (cnt_q == '0);
        if (i_tvalid && o_tready) begin
          cnt_d = cnt_q - 16'd1;
          if (i_tlast) begin
            err_d   = (cnt_q != '0);
            state_d = S_HDR;
          end else if (cnt_q == '0) begin
            err_d   = 1'b1;
            state_d = S_DROP;
          end
        end
      end
      S_DROP: begin
        i_tready = 1'b1;
        if (i_tvalid && i_tlast) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase
    // Reset must hold off the upstream even though ready is combinational.
    if (!reset_n) i_tready = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_HDR;
      cnt_q            <= '0;
      hdr_q            <= '0;
      stb_q            <= 1'b0;
      err_q            <= 1'b0;
      o_pkt_type       <= '0;
      o_eob            <= 1'b0;
      o_has_time       <= 1'b0;
      o_seqnum         <= '0;
      o_payload_length <= '0;
      o_src_sid        <= '0;
      o_dst_sid        <= '0;
      o_vita_time      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      stb_q   <= pub;
      err_q   <= err_d;
      // Fields only change together with the strobe so they stay stable
      // across the payload of their own packet.
      if (pub) begin
        o_pkt_type       <= pub_word[PKT_TYPE_MSB:PKT_TYPE_LSB];
        o_eob            <= pub_word[EOB_BIT];
        o_has_time       <= pub_word[HAS_TIME_BIT];
        o_seqnum         <= pub_word[SEQNUM_MSB:SEQNUM_LSB];
        o_payload_length <= pub_len;
        o_src_sid        <= pub_word[SRC_SID_MSB:SRC_SID_LSB];
        o_dst_sid        <= pub_word[DST_SID_MSB:DST_SID_LSB];
        o_vita_time      <= pub_time;
      end
    end
  end

  assign o_hdr_stb = stb_q;
  assign o_err_len = err_q;

`ifdef CVITA_HDR_PARSER_SEQ_CHECK_EN
  logic [11:0] exp_q;
  logic        seen_q, err_seq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q     <= '0;
      seen_q    <= 1'b0;
      err_seq_q <= 1'b0;
    end else begin
      err_seq_q <= 1'b0;
      if (pub) begin
        err_seq_q <= seen_q && (pub_word[SEQNUM_MSB:SEQNUM_LSB] != exp_q);
        exp_q     <= pub_word[SEQNUM_MSB:SEQNUM_LSB] + 12'd1;
        seen_q    <= 1'b1;
      end
    end
  end

  assign o_err_seq = err_seq_q;
`endif

endmodule

// File: tb/tb_cvita_hdr_parser.sv
// Scoreboard bench for cvita_hdr_parser: expected payload beats are queued
// as stimulus is driven and popped by a monitor on output handshakes.
module tb_cvita_hdr_parser;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] i_tdata = '0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [63:0] o_tdata;
  logic        o_tlast, o_tvalid;
  logic        o_tready = 1'b1;
  logic [1:0]  o_pkt_type;
  logic        o_eob, o_has_time, o_hdr_stb, o_err_len;
  logic [11:0] o_seqnum;
  logic [15:0] o_payload_length, o_src_sid, o_dst_sid;
  logic [63:0] o_vita_time;
`ifdef CVITA_HDR_PARSER_SEQ_CHECK_EN
  logic        o_err_seq;
  int          seq_cnt = 0;
  int          seq_last_pkt = -1;
  int          stb_seen = 0;
`endif

  int total = 0;
  int bad = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  bit rand_rdy = 0;
  logic [64:0] exp_q[$];

  cvita_hdr_parser dut (
    .clk(clk), .reset_n(reset_n),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_pkt_type(o_pkt_type), .o_eob(o_eob), .o_has_time(o_has_time),
    .o_seqnum(o_seqnum), .o_payload_length(o_payload_length),
    .o_src_sid(o_src_sid), .o_dst_sid(o_dst_sid), .o_vita_time(o_vita_time),
    .o_hdr_stb(o_hdr_stb),
`ifdef CVITA_HDR_PARSER_SEQ_CHECK_EN
    .o_err_seq(o_err_seq),
`endif
    .o_err_len(o_err_len)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n) begin
      if (o_tvalid && o_tready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat: unexpected output beat data=%h last=%b", o_tdata, o_tlast);
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          if ({o_tlast, o_tdata} !== e) begin
            bad++;
            $display("FAIL beat: got last=%b data=%h want last=%b data=%h",
                     o_tlast, o_tdata, e[64], e[63:0]);
          end
        end
      end
      if (o_hdr_stb) stb_cnt++;
      if (o_err_len) err_cnt++;
`ifdef CVITA_HDR_PARSER_SEQ_CHECK_EN
      if (o_hdr_stb) stb_seen++;
      if (o_err_seq) begin
        seq_cnt++;
        seq_last_pkt = stb_seen;
      end
`endif
    end
  end

  function automatic logic [63:0] mk_hdr(input logic [1:0] t, input logic ht,
      input logic eob, input logic [11:0] seq, input logic [15:0] len,
      input logic [15:0] src, input logic [15:0] dst);
    return {t, ht, eob, seq, len, src, dst};
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic l);
    int n;
    bit done;
    n = 0;
    done = 0;
    i_tvalid = 1'b1;
    i_tdata  = d;
    i_tlast  = l;
    while (!done) begin
      o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      done = i_tready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        total++;
        bad++;
        $display("FAIL handshake: no i_tready within %0d cycles, want 1", n);
        done = 1;
      end
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    i_tdata  = '0;
  endtask

  // Payload beat that is also queued as expected output.
  task automatic send_exp(input logic [63:0] d, input logic l, input logic exp_last);
    exp_q.push_back({exp_last, d});
    send_beat(d, l);
  endtask

  task automatic idle(input int n);
    o_tready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_pkt(input string name, input int s0, input int e0,
                           input int ds, input int de);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_beats: %0d beats outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
    total++;
    if (stb_cnt - s0 != ds) begin
      bad++;
      $display("FAIL %s_stb: got %0d strobes, want %0d", name, stb_cnt - s0, ds);
    end
    total++;
    if (err_cnt - e0 != de) begin
      bad++;
      $display("FAIL %s_err: got %0d errors, want %0d", name, err_cnt - e0, de);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    i_tvalid = 1'b1;
    #1;
    total++;
    if ({i_tready, o_tvalid, o_tlast, o_hdr_stb, o_err_len} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl: got rdy/vld/last/stb/err=%b want 00000",
               {i_tready, o_tvalid, o_tlast, o_hdr_stb, o_err_len});
    end
    total++;
    if ({o_tdata, o_vita_time, o_payload_length, o_seqnum} !== '0) begin
      bad++;
      $display("FAIL reset_data: got tdata=%h time=%h len=%h seq=%h want 0",
               o_tdata, o_vita_time, o_payload_length, o_seqnum);
    end
    i_tvalid = 1'b0;
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    int s0, e0;
    s0 = stb_cnt; e0 = err_cnt;
    send_beat(mk_hdr(2'b00, 1'b0, 1'b1, 12'd1, 16'd32, 16'hABCD, 16'h1234), 1'b0);
    send_exp(64'h1111_0000_0000_0001, 1'b0, 1'b0);
    send_exp(64'h1111_0000_0000_0002, 1'b0, 1'b0);
    send_exp(64'h1111_0000_0000_0003, 1'b1, 1'b1);
    idle(3);
    check_pkt("basic", s0, e0, 1, 0);
    total++;
    if ({o_payload_length, o_seqnum, o_src_sid, o_dst_sid, o_eob, o_has_time, o_pkt_type}
        !== {16'd24, 12'd1, 16'hABCD, 16'h1234, 1'b1, 1'b0, 2'b00}) begin
      bad++;
      $display("FAIL basic_fields: got len=%0d seq=%0d src=%h dst=%h eob=%b ht=%b want 24 1 abcd 1234 1 0",
               o_payload_length, o_seqnum, o_src_sid, o_dst_sid, o_eob, o_has_time);
    end
    total++;
    if (o_vita_time !== 64'd0) begin
      bad++;
      $display("FAIL basic_time: got %h want 0", o_vita_time);
    end
  endtask

  task automatic test_time();
    int s0, e0;
    s0 = stb_cnt; e0 = err_cnt;
    send_beat(mk_hdr(2'b10, 1'b1, 1'b0, 12'd5, 16'd28, 16'h0001, 16'h0002), 1'b0);
    send_beat(64'h1234, 1'b0);
    send_exp(64'h2222_0000_0000_0001, 1'b0, 1'b0);
    send_exp(64'h2222_0000_0000_0002, 1'b1, 1'b1);
    idle(3);
    check_pkt("time", s0, e0, 1, 0);
    total++;
    if ({o_vita_time, o_payload_length, o_seqnum, o_has_time, o_pkt_type}
        !== {64'h1234, 16'd12, 12'd5, 1'b1, 2'b10}) begin
      bad++;
      $display("FAIL time_fields: got time=%h len=%0d seq=%0d ht=%b type=%b want 1234 12 5 1 10",
               o_vita_time, o_payload_length, o_seqnum, o_has_time, o_pkt_type);
    end
  endtask

  task automatic test_early_tlast();
    int s0, e0;
    s0 = stb_cnt; e0 = err_cnt;
    send_beat(mk_hdr(2'b00, 1'b0, 1'b0, 12'd6, 16'd40, 16'h0003, 16'h0004), 1'b0);
    send_exp(64'h3333_0000_0000_0001, 1'b0, 1'b0);
    send_exp(64'h3333_0000_0000_0002, 1'b1, 1'b1);
    idle(3);
    check_pkt("early", s0, e0, 1, 1);
  endtask

  task automatic test_overrun();
    int s0, e0;
    s0 = stb_cnt; e0 = err_cnt;
    send_beat(mk_hdr(2'b00, 1'b0, 1'b0, 12'd7, 16'd16, 16'h0005, 16'h0006), 1'b0);
    send_exp(64'h4444_0000_0000_0001, 1'b0, 1'b1);
    send_beat(64'h4444_0000_0000_0002, 1'b0);
    send_beat(64'h4444_0000_0000_0003, 1'b0);
    send_beat(64'h4444_0000_0000_0004, 1'b1);
    send_beat(mk_hdr(2'b00, 1'b0, 1'b0, 12'd8, 16'd24, 16'h0007, 16'h0008), 1'b0);
    send_exp(64'h5555_0000_0000_0001, 1'b0, 1'b0);
    send_exp(64'h5555_0000_0000_0002, 1'b1, 1'b1);
    idle(3);
    check_pkt("overrun", s0, e0, 2, 1);
    total++;
    if ({o_payload_length, o_seqnum} !== {16'd16, 12'd8}) begin
      bad++;
      $display("FAIL overrun_next: got len=%0d seq=%0d want 16 8", o_payload_length, o_seqnum);
    end
  endtask

  task automatic test_hdr_only();
    int s0, e0;
    s0 = stb_cnt; e0 = err_cnt;
    send_beat(mk_hdr(2'b01, 1'b0, 1'b0, 12'd9, 16'd8, 16'h0009, 16'h000A), 1'b1);
    idle(2);
    check_pkt("hdronly", s0, e0, 1, 0);
    total++;
    if ({o_payload_length, o_pkt_type} !== {16'd0, 2'b01}) begin
      bad++;
      $display("FAIL hdronly_len: got len=%0d type=%b want 0 01", o_payload_length, o_pkt_type);
    end
    s0 = stb_cnt; e0 = err_cnt;
    send_beat(mk_hdr(2'b00, 1'b0, 1'b0, 12'd10, 16'd4, 16'h0, 16'h0), 1'b1);
    send_beat(mk_hdr(2'b00, 1'b1, 1'b0, 12'd11, 16'd16, 16'h0, 16'h0), 1'b0);
    send_beat(64'hBEEF, 1'b1);
    idle(2);
    check_pkt("short_and_timeonly", s0, e0, 1, 1);
    total++;
    if ({o_vita_time, o_payload_length} !== {64'hBEEF, 16'd0}) begin
      bad++;
      $display("FAIL timeonly_fields: got time=%h len=%0d want beef 0", o_vita_time, o_payload_length);
    end
  endtask

  task automatic test_backpressure();
    int s0, e0;
    s0 = stb_cnt; e0 = err_cnt;
    rand_rdy = 1;
    send_beat(mk_hdr(2'b00, 1'b0, 1'b0, 12'd12, 16'd808, 16'h0B, 16'h0C), 1'b0);
    for (int i = 0; i < 100; i++)
      send_exp({32'hC0DE_0000, 32'($urandom)}, i == 99, i == 99);
    rand_rdy = 0;
    idle(3);
    check_pkt("bp", s0, e0, 1, 0);
  endtask

  task automatic test_reset_mid();
    int s0, e0;
    send_beat(mk_hdr(2'b00, 1'b0, 1'b0, 12'd13, 16'd80, 16'h0D, 16'h0E), 1'b0);
    for (int i = 0; i < 3; i++) send_exp(64'h6666_0000_0000_0000 + 64'(i), 1'b0, 1'b0);
    i_tvalid = 1'b1;
    i_tdata  = 64'h7777;
    reset_n  = 1'b0;
    #1;
    total++;
    if ({i_tready, o_tvalid, o_tlast, o_hdr_stb, o_err_len} !== 5'b0 ||
        {o_tdata, o_payload_length, o_seqnum, o_src_sid} !== '0) begin
      bad++;
      $display("FAIL midreset: got rdy/vld=%b%b tdata=%h len=%0d seq=%0d want all 0",
               i_tready, o_tvalid, o_tdata, o_payload_length, o_seqnum);
    end
    i_tvalid = 1'b0;
    i_tdata  = '0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
    s0 = stb_cnt; e0 = err_cnt;
    send_beat(mk_hdr(2'b00, 1'b0, 1'b0, 12'd14, 16'd16, 16'h0F, 16'h10), 1'b0);
    send_exp(64'h8888, 1'b1, 1'b1);
    idle(3);
    check_pkt("after_reset", s0, e0, 1, 0);
  endtask

`ifdef CVITA_HDR_PARSER_SEQ_CHECK_EN
  task automatic test_seq();
    logic [11:0] seqs[4];
    seqs = '{12'd4094, 12'd4095, 12'd0, 12'd2};
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
    stb_seen = 0;
    seq_cnt = 0;
    for (int i = 0; i < 4; i++)
      send_beat(mk_hdr(2'b00, 1'b0, 1'b0, seqs[i], 16'd8, 16'h0, 16'h0), 1'b1);
    idle(3);
    total++;
    if (seq_cnt != 1 || seq_last_pkt != 4) begin
      bad++;
      $display("FAIL seq: got %0d flags last on pkt %0d want 1 flag on pkt 4", seq_cnt, seq_last_pkt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_time();
    test_early_tlast();
    test_overrun();
    test_hdr_only();
    test_backpressure();
    test_reset_mid();
`ifdef CVITA_HDR_PARSER_SEQ_CHECK_EN
    test_seq();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cvita_hdr_parser.md
Name: cvita_hdr_parser

Overview:
- Receive-side counterpart of the CVITA header encoder.
- Accepts a 64-bit AXI-Stream of CVITA packets, then splits each packet into registered header fields plus a payload-only AXI-Stream.
- Sits between the crossbar/transport input and NoC block logic.
- Checks packet length against tlast, and forces correct framing on the output stream.

Parameters:
- MAX_LEN_BYTES, 16'hFFFF, largest accepted CVITA length field. Larger headers are flagged and the packet is dropped.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- i_tdata  in  64  CVITA packet words
- i_tlast  in  1  last word of input packet
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o_tdata  out  64  payload words
- o_tlast  out  1  last payload word
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready
- o_pkt_type  out  2  header [63:62]
- o_eob  out  1  header [60]
- o_has_time  out  1  header [61]
- o_seqnum  out  12  header [59:48]
- o_payload_length  out  16  length field minus 16 if has_time, else minus 8
- o_src_sid  out  16  header [31:16]
- o_dst_sid  out  16  header [15:0]
- o_vita_time  out  64  timestamp word; 0 when has_time=0
- o_hdr_stb  out  1  one-cycle pulse when header fields become valid
- o_err_len  out  1  one-cycle pulse on framing/length error

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-low, reset_n.
- On reset:
  - all outputs are 0 and i_tready=0 while reset_n=0;
  - state returns to S_HDR;
  - a packet in flight is abandoned with no partial output.
- States: S_HDR, S_TIME, S_BODY, S_DROP.
- S_HDR:
  - i_tready=1; on handshake, register all header fields.
  - Length field L is word[47:32]; hdr_len is 16 if has_time, else 8.
  - Error if L < hdr_len, L > MAX_LEN_BYTES, or i_tlast=1 while has_time=1:
    - if i_tlast=1: pulse o_err_len, stay in S_HDR;
    - if i_tlast=0: pulse o_err_len, go to S_DROP.
  - Otherwise:
    - has_time=1: go to S_TIME;
    - has_time=0 and L=8 (header only, i_tlast must be 1): pulse o_hdr_stb, stay in S_HDR, no output beat;
    - has_time=0 and L=8 with i_tlast=0: pulse o_hdr_stb, pulse o_err_len, go to S_DROP;
    - has_time=0 and L>8: o_vita_time=0, pulse o_hdr_stb, go to S_BODY.
- S_TIME:
  - i_tready=1; on handshake, o_vita_time <= word and pulse o_hdr_stb.
  - If L=16: go to S_HDR; if i_tlast=0, also pulse o_err_len and go to S_DROP instead.
  - Else if i_tlast=1: pulse o_err_len, go to S_HDR.
  - Else: go to S_BODY.
- Header field timing: header outputs hold from o_hdr_stb until the next o_hdr_stb. They are stable for every payload beat of their packet.
- S_BODY:
  - Pass-through with zero latency: o_tdata=i_tdata, o_tvalid=i_tvalid, i_tready=o_tready.
  - Beat counter loads ceil(o_payload_length/8)-1 on entry and decrements per output handshake.
  - o_tlast = i_tlast OR (counter==0).
  - Early i_tlast (counter>0): beat passes with o_tlast=1, o_err_len pulses, go to S_HDR.
  - Counter==0 with i_tlast=1: go to S_HDR, no error.
  - Counter==0 with i_tlast=0: o_tlast=1, pulse o_err_len, go to S_DROP.
- S_DROP: i_tready=1, o_tvalid=0; consume input until the i_tlast handshake, then go to S_HDR.
- Backpressure: o_tvalid never deasserts without a handshake while the input holds valid, because it follows the AXI input directly.
- Throughput: one beat per cycle in S_BODY. Header and time words each cost one cycle with no output beat.
- Arithmetic: all length arithmetic is 16-bit unsigned. ceil is computed as (len+7)>>3 in 17 bits.

Optional Feature:
- Macro: CVITA_HDR_PARSER_SEQ_CHECK_EN.
- When defined:
  - adds output o_err_seq (1 bit) and an internal 12-bit expected-seqnum register per parser, reset 0;
  - on each accepted header, o_err_seq pulses if seqnum != expected;
  - expected is then set to seqnum+1, modulo 4096, wrapping 4095 to 0;
  - the first header after reset never flags.
- When undefined: port and logic are absent; seqnum is passed through only.

Decomposition:
- Package cvita_pkg holds:
  - field bit-position constants (PKT_TYPE_MSB/LSB, HAS_TIME_BIT, EOB_BIT, SEQNUM_MSB/LSB, LEN_MSB/LSB, SRC_SID, DST_SID);
  - pkt_type codes (DATA=2'b00, FC=2'b01, CMD=2'b10, RESP=2'b11);
  - header length constants 8 and 16.
- No sub-module: a single FSM with a counter is natural; shares field constants with the encoder.

Test Plan:
- Data packet, has_time=0, L=32, 3 payload beats with tlast on beat 3 -> o_hdr_stb once, payload_length=24, 3 output beats with o_tlast on the 3rd, no error.
- has_time=1, L=28, time=64'h1234, seqnum=5 -> o_vita_time=64'h1234, payload_length=12, 2 output beats, o_tlast on the 2nd.
- Header claims L=40 but tlast arrives on payload beat 2 -> 2 output beats, o_tlast on the 2nd, o_err_len pulses once.
- Header claims L=16 (has_time=0) but 4 payload beats are sent -> 1 output beat with o_tlast, remaining 3 dropped, o_err_len pulses, next packet parses correctly.
- Random o_tready deassertion over a 100-beat packet -> data matches input in order, no loss or duplication; reset_n pulled low mid-packet -> all outputs 0 immediately, next packet parsed cleanly.
- With CVITA_HDR_PARSER_SEQ_CHECK_EN: seqnums 4094, 4095, 0, 2 -> o_err_seq only on the 4th packet.
